// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and ROM address helper for the sprite blitter.
package sprite_pkg;

    localparam int SPRITE_W   = 16;
    localparam int SPRITE_H   = 16;
    localparam int ROM_ADDR_W = 8;
    localparam int COLOR_W    = 3;
    localparam int X_W        = 8;
    localparam int Y_W        = 7;
    localparam int PX_W       = $clog2(SPRITE_W);
    localparam int PY_W       = $clog2(SPRITE_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

    // SPRITE_W is a power of two, so px + SPRITE_W*py is a plain concatenation
    function automatic logic [ROM_ADDR_W-1:0] raster_addr(
        input logic [PX_W-1:0] px,
        input logic [PY_W-1:0] py
    );
        return ROM_ADDR_W'({py, px});
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Start/busy/done handshake, sprite ROM port and VGA plot port of the sprite blitter.
interface sprite_blitter_if;
    import sprite_pkg::*;

    logic                  start;
    logic [X_W-1:0]        base_x;
    logic [Y_W-1:0]        base_y;
    logic                  busy;
    logic                  done;
    logic [ROM_ADDR_W-1:0] rom_address;
    logic [COLOR_W-1:0]    rom_data;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [COLOR_W-1:0]    vga_colour;
    logic                  vga_plot;

    modport master (
        output start, base_x, base_y, rom_data,
        input  busy, done, rom_address, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  start, base_x, base_y, rom_data,
        output busy, done, rom_address, vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/sprite_scan_counter.sv
// Raster-order px/py counter over the sprite; clr wins over en, py wraps after the last row.
module sprite_scan_counter
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr,
    input  logic                  en,
    output logic [PX_W-1:0]       px,
    output logic [PY_W-1:0]       py,
    output logic [ROM_ADDR_W-1:0] address,
    output logic                  last
);

    localparam logic [PX_W-1:0] PX_MAX = PX_W'(SPRITE_W - 1);
    localparam logic [PY_W-1:0] PY_MAX = PY_W'(SPRITE_H - 1);

    logic [PX_W-1:0] px_q, px_d;
    logic [PY_W-1:0] py_q, py_d;

    // next raster position
    always_comb begin
        px_d = px_q;
        py_d = py_q;
        if (clr) begin
            px_d = {PX_W{1'b0}};
            py_d = {PY_W{1'b0}};
        end else if (en) begin
            if (px_q == PX_MAX) begin
                px_d = {PX_W{1'b0}};
                py_d = py_q + PY_W'(1);
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end else begin
            px_d = px_q;
        end
    end

    // position registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            px_q <= {PX_W{1'b0}};
            py_q <= {PY_W{1'b0}};
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

    assign px      = px_q;
    assign py      = py_q;
    assign address = raster_addr(px_q, py_q);
    assign last    = (px_q == PX_MAX) && (py_q == PY_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// Scans a 16x16 sprite ROM and emits offset plot requests to the VGA adapter.
// Optional SPRITE_BLIT_TRANSPARENCY_EN suppresses plots of KEY_COLOUR pixels.
module sprite_blitter
    import sprite_pkg::*;
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
#(
    parameter logic [COLOR_W-1:0] KEY_COLOUR = 3'b000
)
`endif
(
    input  logic             clk,
    input  logic             resetn,
    sprite_blitter_if.slave  bus
);

    blit_state_e        state_q, state_d;
    logic [X_W-1:0]     base_x_q, base_x_d;
    logic [Y_W-1:0]     base_y_q, base_y_d;
    logic               s1_valid_q, s1_valid_d;
    logic [PX_W-1:0]    s1_px_q, s1_px_d;
    logic [PY_W-1:0]    s1_py_q, s1_py_d;
    logic [X_W-1:0]     vga_x_q, vga_x_d;
    logic [Y_W-1:0]     vga_y_q, vga_y_d;
    logic [COLOR_W-1:0] vga_colour_q, vga_colour_d;
    logic               vga_plot_q, vga_plot_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic                  cnt_clr_s;
    logic                  cnt_en_s;
    logic [PX_W-1:0]       px_s;
    logic [PY_W-1:0]       py_s;
    logic [ROM_ADDR_W-1:0] addr_s;
    logic                  last_s;
    logic                  pix_plot_s;

    sprite_scan_counter u_scan (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .px      (px_s),
        .py      (py_s),
        .address (addr_s),
        .last    (last_s)
    );

    // FSM next state, base capture and counter control
    always_comb begin
        state_d   = state_q;
        base_x_d  = base_x_q;
        base_y_d  = base_y_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = READ;
                    base_x_d  = bus.base_x;
                    base_y_d  = bus.base_y;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                cnt_en_s = 1'b1;
                if (last_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = READ;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SPRITE_BLIT_TRANSPARENCY_EN
    assign pix_plot_s = s1_valid_q && (bus.rom_data != KEY_COLOUR);
`else
    assign pix_plot_s = s1_valid_q;
`endif

    // pipeline stage 1 tracks the issued address; stage 2 forms the plot request
    always_comb begin
        s1_valid_d   = (state_q == READ);
        s1_px_d      = px_s;
        s1_py_d      = py_s;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (s1_valid_q) begin
            vga_x_d      = base_x_q + X_W'(s1_px_q);
            vga_y_d      = base_y_q + Y_W'(s1_py_q);
            vga_colour_d = bus.rom_data;
            vga_plot_d   = pix_plot_s;
        end else begin
            vga_plot_d   = 1'b0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // state, pipeline and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            base_x_q     <= {X_W{1'b0}};
            base_y_q     <= {Y_W{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_px_q      <= {PX_W{1'b0}};
            s1_py_q      <= {PY_W{1'b0}};
            vga_x_q      <= {X_W{1'b0}};
            vga_y_q      <= {Y_W{1'b0}};
            vga_colour_q <= {COLOR_W{1'b0}};
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_x_q     <= base_x_d;
            base_y_q     <= base_y_d;
            s1_valid_q   <= s1_valid_d;
            s1_px_q      <= s1_px_d;
            s1_py_q      <= s1_py_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.rom_address = addr_s;
    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.vga_plot    = vga_plot_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: stimulus queues expected plots/done/busy, a monitor checks them.
module tb_sprite_blitter;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    exp_t pq[$];
    int   dq[$];
    bit   busy_map[int];
    int   last_x = 0;
    int   last_y = 0;
    int   last_c = 0;

    sprite_blitter_if bus();

    sprite_blitter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // sprite ROM model: colour = addr[2:0], one cycle latency
    always @(posedge clk) bus.rom_data <= bus.rom_address[2:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_blit(input int s, input int bx, input int by);
        exp_t e;
        for (int k = 0; k < 256; k++) begin
            e.x   = (bx + (k % 16)) % 256;
            e.y   = (by + (k / 16)) % 128;
            e.c   = k % 8;
            e.cyc = s + 3 + k;
`ifdef SPRITE_BLIT_TRANSPARENCY_EN
            if (e.c != 0) pq.push_back(e);
`else
            pq.push_back(e);
`endif
        end
        for (int c = s + 1; c <= s + 258; c++) busy_map[c] = 1'b1;
        dq.push_back(s + 258);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rom_address"}, 32'(bus.rom_address), 32'd0);
        check({tag, "_vga_x"}, 32'(bus.vga_x), 32'd0);
        check({tag, "_vga_y"}, 32'(bus.vga_y), 32'd0);
        check({tag, "_vga_colour"}, 32'(bus.vga_colour), 32'd0);
        check({tag, "_vga_plot"}, 32'(bus.vga_plot), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    // monitor: sampled 1 time unit after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                while (pq.size() > 0 && pq[0].cyc < cyc) begin
                    check("plot_missing", 32'(cyc), 32'(pq[0].cyc));
                    void'(pq.pop_front());
                end
                if (bus.vga_plot === 1'b1) begin
                    if (pq.size() == 0) begin
                        check("plot_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = pq.pop_front();
                        check("plot_cycle", 32'(cyc), 32'(e.cyc));
                        check("plot_x", 32'(bus.vga_x), 32'(e.x));
                        check("plot_y", 32'(bus.vga_y), 32'(e.y));
                        check("plot_colour", 32'(bus.vga_colour), 32'(e.c));
                        last_x = e.x;
                        last_y = e.y;
                        last_c = e.c;
                    end
                end else begin
                    check("plot_low", 32'(bus.vga_plot), 32'd0);
`ifndef SPRITE_BLIT_TRANSPARENCY_EN
                    check("hold_x", 32'(bus.vga_x), 32'(last_x));
                    check("hold_y", 32'(bus.vga_y), 32'(last_y));
                    check("hold_colour", 32'(bus.vga_colour), 32'(last_c));
`endif
                end
                while (dq.size() > 0 && dq[0] < cyc) begin
                    check("done_missing", 32'(cyc), 32'(dq[0]));
                    void'(dq.pop_front());
                end
                if (bus.done === 1'b1) begin
                    if (dq.size() > 0 && dq[0] == cyc) begin
                        check("done_cycle", 32'(cyc), 32'(dq.pop_front()));
                    end else begin
                        check("done_unexpected", 32'd1, 32'd0);
                    end
                end else begin
                    check("done_low", 32'(bus.done), 32'd0);
                end
                check("busy", 32'(bus.busy), 32'(busy_map.exists(cyc)));
            end
        end
    end

    // stimulus
    initial begin
        int s;
        int keys[$];
        resetn     = 1'b0;
        bus.start  = 1'b1;
        bus.base_x = 8'd0;
        bus.base_y = 7'd0;

        // reset held two cycles with start high
        goto(2);
        check_zero("reset");
        resetn    = 1'b1;
        bus.start = 1'b0;
        mon_en    = 1'b1;

        // basic blit with ignored start pulses during READ and DONE
        goto(5);
        bus.base_x = 8'd10;
        bus.base_y = 7'd20;
        bus.start  = 1'b1;
        s = cyc;
        push_blit(s, 10, 20);
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 50);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 258);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 290);

        // coordinate wrap
        bus.base_x = 8'd250;
        bus.base_y = 7'd120;
        bus.start  = 1'b1;
        s = cyc;
        push_blit(s, 250, 120);
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 270);

        // start held high: back-to-back blits, base changed mid-blit
        bus.base_x = 8'd30;
        bus.base_y = 7'd40;
        bus.start  = 1'b1;
        s = cyc;
        push_blit(s, 30, 40);
        goto(s + 5);
        bus.base_x = 8'd5;
        bus.base_y = 7'd6;
        push_blit(s + 259, 5, 6);
        goto(s + 260);
        bus.start = 1'b0;
        goto(s + 259 + 270);

        // reset in the middle of a blit
        bus.base_x = 8'd100;
        bus.base_y = 7'd50;
        bus.start  = 1'b1;
        s = cyc;
        push_blit(s, 100, 50);
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 100);
        resetn = 1'b0;
        pq.delete();
        dq.delete();
        keys.delete();
        foreach (busy_map[k]) if (k > cyc) keys.push_back(k);
        foreach (keys[i]) busy_map.delete(keys[i]);
        last_x = 0;
        last_y = 0;
        last_c = 0;
        @(negedge clk);
        check_zero("midreset");
        resetn = 1'b1;
        goto(s + 110);

        // full blit after the aborted one
        bus.base_x = 8'd7;
        bus.base_y = 7'd9;
        bus.start  = 1'b1;
        s = cyc;
        push_blit(s, 7, 9);
        @(negedge clk);
        bus.start = 1'b0;
        goto(s + 275);

        check("plots_left", 32'(pq.size()), 32'd0);
        check("dones_left", 32'(dq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
